// File: rtl/mixer_pkg.sv
// Shared types and defaults for the RF x LO mixer and its decimating accumulator.
package mixer_pkg;

  localparam int RF_OFFSET_DEF = 128;
  localparam int LO_OFFSET_DEF = 100;
  localparam int DECIM_DEF     = 16;
  localparam int SAMPLE_W      = 9;
  localparam int PROD_W        = 18;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0]   prod_t;

  // A window of DECIM products needs log2(DECIM) guard bits above the product.
  function automatic int acc_width(input int decim);
    return PROD_W + $clog2(decim);
  endfunction

endpackage

// File: rtl/mixer_mult.sv
// Offset removal and a registered signed multiply, with a valid flag
// travelling alongside each stage.
module mixer_mult
  import mixer_pkg::*;
#(
  parameter int RF_OFFSET = RF_OFFSET_DEF,
  parameter int LO_OFFSET = LO_OFFSET_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rf_in,
  input  logic       rf_valid,
  input  logic [7:0] lo_in,
  output prod_t      prod,
  output logic       prod_valid
);

  sample_t rf_s;
  sample_t lo_s;
  logic    v1;

  // Unsigned 9-bit subtraction wraps into the correct two's-complement value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_s       <= '0;
      lo_s       <= '0;
      v1         <= 1'b0;
      prod       <= '0;
      prod_valid <= 1'b0;
    end else begin
      v1 <= rf_valid;
      if (rf_valid) begin
        rf_s <= sample_t'({1'b0, rf_in} - 9'(RF_OFFSET));
        lo_s <= sample_t'({1'b0, lo_in} - 9'(LO_OFFSET));
      end
      prod_valid <= v1;
      if (v1) begin
        prod <= prod_t'(rf_s) * prod_t'(lo_s);
      end
    end
  end

endmodule

// File: rtl/mixer_acc.sv
// Mixes offset-binary RF with the LO and emits one signed sum per DECIM
// valid products, with a one-cycle strobe.
module mixer_acc
  import mixer_pkg::*;
#(
  parameter int RF_OFFSET = RF_OFFSET_DEF,
  parameter int LO_OFFSET = LO_OFFSET_DEF,
  parameter int DECIM     = DECIM_DEF,
  parameter int ACC_W     = acc_width(DECIM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rf_in,
  input  logic                    rf_valid,
  input  logic [7:0]              lo_in,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    acc_valid
);

  localparam int CNT_W = $clog2(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  prod_t                   prod;
  logic                    v2;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;

  mixer_mult #(
    .RF_OFFSET (RF_OFFSET),
    .LO_OFFSET (LO_OFFSET)
  ) u_mult (
    .clk        (clk),
    .rst        (rst),
    .rf_in      (rf_in),
    .rf_valid   (rf_valid),
    .lo_in      (lo_in),
    .prod       (prod),
    .prod_valid (v2)
  );

  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // The closing product goes straight into acc_out so the next window starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (v2) begin
        if (cnt == CNT_LAST) begin
          acc_out   <= acc + prod_ext;
          acc_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc + prod_ext;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
